// File: rtl/vic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vic_ctrl
//  Purpose  : Controller around the vectored interrupt unit. It holds the
//             per-line configuration and the vector table (both reached over
//             a simple CPU register bus). It latches interrupt events into a
//             pending bitmap and dispatches the highest-priority line
//             (lowest index). It also runs the CPU request / acknowledge /
//             end-of-interrupt handshake.
//  Ports    : i_clk, i_rst (async, active-low)
//             i_wr, i_rd, i_addr, i_wdata, o_rdata, o_rdy  - register bus
//             i_irq_pulse, i_irq_addr                      - events from unit
//             o_reg, o_en, o_busy                          - to unit
//             o_cpu_irq, o_vector, o_cur, i_cpu_ack, i_cpu_eoi - CPU side
//  Revision : 1.0 - initial release
// ============================================================================
module vic_ctrl #(
    parameter int N_IRQ       = 31,
    parameter int VEC_W       = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic               i_rd,
    input  logic [7:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_rdy,
    input  logic               i_irq_pulse,
    input  logic [4:0]         i_irq_addr,
    output logic [4*N_IRQ-1:0] o_reg,
    output logic               o_en,
    output logic               o_busy,
    output logic               o_cpu_irq,
    output logic [VEC_W-1:0]   o_vector,
    output logic [4:0]         o_cur,
    input  logic               i_cpu_ack,
    input  logic               i_cpu_eoi
);

    localparam int c_CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    // The counter starts at 0 on the first REQ cycle, so the request is
    // withdrawn at the end of REQ cycle number ACK_TIMEOUT.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    localparam logic [7:0] c_A_CTRL     = 8'h40;
    localparam logic [7:0] c_A_PENDING  = 8'h41;
    localparam logic [7:0] c_A_CUR      = 8'h42;
    localparam logic [7:0] c_A_PEND_CLR = 8'h43;

    logic [3:0]         r_cfg [N_IRQ];
    logic [VEC_W-1:0]   r_vec [N_IRQ];
    logic               r_en;
    logic [N_IRQ-1:0]   r_pending;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_cur;
    logic [VEC_W-1:0]   r_vector;
    logic               r_cpu_irq;
    logic               r_busy;
    logic [31:0]        r_rdata;
    logic               r_rdy;

    logic               w_is_cfg;
    logic               w_is_vec;
    logic [4:0]         w_idx;
    logic               w_irq_ok;
    logic [31:0]        w_rdata;
    logic [4:0]         w_sel_idx;
    logic               w_dispatch;
    logic               w_timeout;
    logic [N_IRQ-1:0]   w_pend_next;
    logic               w_unused_wdata;

    // Only the low bits of most registers are implemented.
    assign w_unused_wdata = ^i_wdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_idx    = i_addr[4:0];
    assign w_is_cfg = (i_addr[7:5] == 3'b000) && ({3'b000, w_idx} < 8'(N_IRQ));
    assign w_is_vec = (i_addr[7:5] == 3'b001) && ({3'b000, w_idx} < 8'(N_IRQ));
    assign w_irq_ok = ({3'b000, i_irq_addr} < 8'(N_IRQ));

    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            w_rdata = {28'd0, r_cfg[w_idx]};
        end else if (w_is_vec) begin
            w_rdata = 32'(r_vec[w_idx]);
        end else if (i_addr == c_A_CTRL) begin
            w_rdata = {31'd0, r_en};
        end else if (i_addr == c_A_PENDING) begin
            w_rdata = 32'(r_pending);
        end else if (i_addr == c_A_CUR) begin
            w_rdata = {22'd0, r_state, 3'd0, r_cur};
        end
    end

    // ------------------------------------------------------------------
    // Priority select: lowest set index wins
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel_idx = 5'(i);
            end
        end
    end

    assign w_dispatch = (r_state == c_ST_IDLE) && r_en && (|r_pending);
    // Acknowledge takes precedence over a simultaneous timeout.
    assign w_timeout  = (r_state == c_ST_REQ) && !i_cpu_ack &&
                        (!r_en || (r_cnt == c_CNT_LAST));

    // ------------------------------------------------------------------
    // Pending next-state. Later assignments override earlier ones, so the
    // event set is applied last and beats every clear.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pending;
        if (i_wr && w_is_cfg && !i_wdata[3]) begin
            w_pend_next[w_idx] = 1'b0;
        end
        if (i_wr && (i_addr == c_A_PEND_CLR)) begin
            w_pend_next = w_pend_next & ~i_wdata[N_IRQ-1:0];
        end
        if (w_dispatch) begin
            w_pend_next[w_sel_idx] = 1'b0;
        end
        if (w_timeout) begin
            w_pend_next[r_cur] = 1'b1;
        end
        if (i_irq_pulse && w_irq_ok) begin
            w_pend_next[i_irq_addr] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register file and bus response
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < N_IRQ; i++) begin
                r_cfg[i] <= '0;
                r_vec[i] <= '0;
            end
            r_en      <= 1'b0;
            r_pending <= '0;
            r_rdata   <= '0;
            r_rdy     <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_rdy     <= i_wr | i_rd;
            // Read data comes from the pre-edge contents, so a simultaneous
            // write returns the old value.
            if (i_rd) begin
                r_rdata <= w_rdata;
            end
            if (i_wr) begin
                if (w_is_cfg) begin
                    r_cfg[w_idx] <= i_wdata[3:0];
                end
                if (w_is_vec) begin
                    r_vec[w_idx] <= i_wdata[VEC_W-1:0];
                end
                if (i_addr == c_A_CTRL) begin
                    r_en <= i_wdata[0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Dispatch / handshake state machine
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_cur     <= '0;
            r_vector  <= '0;
            r_cpu_irq <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_dispatch) begin
                        r_cur     <= w_sel_idx;
                        r_vector  <= r_vec[w_sel_idx];
                        r_cpu_irq <= 1'b1;
                        r_state   <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (i_cpu_ack) begin
                        r_cpu_irq <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= c_ST_SERVICE;
                    end else if (w_timeout) begin
                        r_cpu_irq <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_SERVICE: begin
                    if (i_cpu_eoi) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end
                // One idle cycle with busy low guarantees the unit sees a
                // falling edge between consecutive services.
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_reg
        assign o_reg[4*gi +: 4] = r_cfg[gi];
    end

    assign o_en      = r_en;
    assign o_busy    = r_busy;
    assign o_cpu_irq = r_cpu_irq;
    assign o_vector  = r_vector;
    assign o_cur     = r_cur;
    assign o_rdata   = r_rdata;
    assign o_rdy     = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_vic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vic_ctrl
//  Purpose  : Directed self-checking bench for vic_ctrl (ACK_TIMEOUT = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vic_ctrl;

    logic         i_clk;
    logic         i_rst;
    logic         i_wr;
    logic         i_rd;
    logic [7:0]   i_addr;
    logic [31:0]  i_wdata;
    logic [31:0]  o_rdata;
    logic         o_rdy;
    logic         i_irq_pulse;
    logic [4:0]   i_irq_addr;
    logic [123:0] o_reg;
    logic         o_en;
    logic         o_busy;
    logic         o_cpu_irq;
    logic [15:0]  o_vector;
    logic [4:0]   o_cur;
    logic         i_cpu_ack;
    logic         i_cpu_eoi;

    int n_checks = 0;
    int n_fail   = 0;

    vic_ctrl #(.N_IRQ(31), .VEC_W(16), .ACK_TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_rd(i_rd),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rdy(o_rdy),
        .i_irq_pulse(i_irq_pulse), .i_irq_addr(i_irq_addr), .o_reg(o_reg),
        .o_en(o_en), .o_busy(o_busy), .o_cpu_irq(o_cpu_irq),
        .o_vector(o_vector), .o_cur(o_cur), .i_cpu_ack(i_cpu_ack),
        .i_cpu_eoi(i_cpu_eoi)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        i_wr = 1'b1; i_addr = a; i_wdata = d;
        tick();
        i_wr = 1'b0; i_wdata = '0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        i_rd = 1'b1; i_addr = a;
        tick();
        i_rd = 1'b0;
    endtask

    task automatic pulse(input logic [4:0] line);
        i_irq_pulse = 1'b1; i_irq_addr = line;
        tick();
        i_irq_pulse = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_wr = 0; i_rd = 0; i_addr = '0; i_wdata = '0;
        i_irq_pulse = 0; i_irq_addr = '0; i_cpu_ack = 0; i_cpu_eoi = 0;
        #12;
        n_checks++; if ({o_rdata, o_rdy, o_en, o_busy, o_cpu_irq, o_vector, o_cur} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", {o_rdata, o_rdy, o_en, o_busy, o_cpu_irq, o_vector, o_cur}); end
        n_checks++; if (o_reg !== '0) begin n_fail++; $display("FAIL reset_reg: got %h required 0", o_reg); end
        i_rst = 1'b1;
        tick();
    endtask

    task automatic test_cfg_rw();
        logic [123:0] exp_reg;
        exp_reg = '0; exp_reg[23:20] = 4'hC;
        bus_write(8'h05, 32'hC);
        n_checks++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_rdy: got %b required 1", o_rdy); end
        n_checks++; if (o_reg !== exp_reg) begin n_fail++; $display("FAIL cfg_oreg: got %h required %h", o_reg, exp_reg); end
        bus_read(8'h05);
        n_checks++; if (o_rdata !== 32'hC) begin n_fail++; $display("FAIL cfg_read: got %h required 0000000c", o_rdata); end
        n_checks++; if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL rd_rdy: got %b required 1", o_rdy); end
        tick();
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL rdy_pulse: got %b required 0", o_rdy); end
        bus_read(8'h1F);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", o_rdata); end
        // simultaneous write and read returns pre-write contents
        i_wr = 1'b1; i_rd = 1'b1; i_addr = 8'h05; i_wdata = 32'h3;
        tick();
        i_wr = 1'b0; i_rd = 1'b0;
        n_checks++; if (o_rdata !== 32'hC) begin n_fail++; $display("FAIL wr_rd_old: got %h required 0000000c", o_rdata); end
        bus_read(8'h05);
        n_checks++; if (o_rdata !== 32'h3) begin n_fail++; $display("FAIL wr_rd_new: got %h required 00000003", o_rdata); end
    endtask

    task automatic test_dispatch();
        bus_write(8'h25, 32'h1234);
        bus_write(8'h40, 32'h1);
        n_checks++; if (o_en !== 1'b1) begin n_fail++; $display("FAIL ctrl_en: got %b required 1", o_en); end
        pulse(5'd5);
        n_checks++; if (o_cpu_irq !== 1'b0) begin n_fail++; $display("FAIL disp_early: got %b required 0", o_cpu_irq); end
        tick();
        n_checks++; if (o_cpu_irq !== 1'b1) begin n_fail++; $display("FAIL disp_irq: got %b required 1", o_cpu_irq); end
        n_checks++; if (o_vector !== 16'h1234) begin n_fail++; $display("FAIL disp_vec: got %h required 1234", o_vector); end
        n_checks++; if (o_cur !== 5'd5) begin n_fail++; $display("FAIL disp_cur: got %0d required 5", o_cur); end
        i_cpu_ack = 1'b1; tick(); i_cpu_ack = 1'b0;
        n_checks++; if ({o_busy, o_cpu_irq} !== 2'b10) begin n_fail++; $display("FAIL ack_busy: got busy,irq=%b required 10", {o_busy, o_cpu_irq}); end
        tick();
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL svc_hold: got %b required 1", o_busy); end
        i_cpu_eoi = 1'b1; tick(); i_cpu_eoi = 1'b0;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL eoi_busy: got %b required 0", o_busy); end
        bus_read(8'h42);
        n_checks++; if (o_rdata !== 32'h305) begin n_fail++; $display("FAIL done_state: got %h required 00000305", o_rdata); end
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL disp_pending: got %h required 0", o_rdata); end
    endtask

    task automatic test_priority();
        bus_write(8'h22, 32'hBEEF);
        bus_write(8'h29, 32'h0999);
        bus_write(8'h40, 32'h0);
        pulse(5'd9);
        pulse(5'd2);
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h204) begin n_fail++; $display("FAIL prio_pending: got %h required 00000204", o_rdata); end
        bus_write(8'h40, 32'h1);
        n_checks++; if (o_cpu_irq !== 1'b0) begin n_fail++; $display("FAIL prio_early: got %b required 0", o_cpu_irq); end
        tick();
        n_checks++; if ({o_cpu_irq, o_cur, o_vector} !== {1'b1, 5'd2, 16'hBEEF}) begin n_fail++; $display("FAIL prio_first: got irq=%b cur=%0d vec=%h required 1 2 beef", o_cpu_irq, o_cur, o_vector); end
        bus_write(8'h22, 32'h1111);
        n_checks++; if (o_vector !== 16'hBEEF) begin n_fail++; $display("FAIL vec_hold: got %h required beef", o_vector); end
        i_cpu_ack = 1'b1; tick(); i_cpu_ack = 1'b0;
        i_cpu_eoi = 1'b1; tick(); i_cpu_eoi = 1'b0;
        n_checks++; if ({o_busy, o_cpu_irq} !== 2'b00) begin n_fail++; $display("FAIL prio_done: got busy,irq=%b required 00", {o_busy, o_cpu_irq}); end
        tick();
        n_checks++; if ({o_busy, o_cpu_irq} !== 2'b00) begin n_fail++; $display("FAIL prio_no_b2b: got busy,irq=%b required 00", {o_busy, o_cpu_irq}); end
        tick();
        n_checks++; if ({o_cpu_irq, o_cur, o_vector} !== {1'b1, 5'd9, 16'h0999}) begin n_fail++; $display("FAIL prio_second: got irq=%b cur=%0d vec=%h required 1 9 0999", o_cpu_irq, o_cur, o_vector); end
        i_cpu_ack = 1'b1; tick(); i_cpu_ack = 1'b0;
        i_cpu_eoi = 1'b1; tick(); i_cpu_eoi = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        pulse(5'd3);
        tick();
        n_checks++; if ({o_cpu_irq, o_cur} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL to_disp: got irq=%b cur=%0d required 1 3", o_cpu_irq, o_cur); end
        for (int k = 0; k < 7; k++) begin
            tick();
            n_checks++; if (o_cpu_irq !== 1'b1) begin n_fail++; $display("FAIL to_hold%0d: got %b required 1", k, o_cpu_irq); end
        end
        tick();
        n_checks++; if (o_cpu_irq !== 1'b0) begin n_fail++; $display("FAIL to_withdraw: got %b required 0", o_cpu_irq); end
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h8) begin n_fail++; $display("FAIL to_pending: got %h required 00000008", o_rdata); end
        n_checks++; if ({o_cpu_irq, o_cur} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL to_redisp: got irq=%b cur=%0d required 1 3", o_cpu_irq, o_cur); end
        i_cpu_ack = 1'b1; tick(); i_cpu_ack = 1'b0;
        i_cpu_eoi = 1'b1; tick(); i_cpu_eoi = 1'b0;
        tick();
    endtask

    task automatic test_w1c();
        bus_write(8'h40, 32'h0);
        i_wr = 1'b1; i_addr = 8'h43; i_wdata = 32'h8;
        i_irq_pulse = 1'b1; i_irq_addr = 5'd3;
        tick();
        i_wr = 1'b0; i_irq_pulse = 1'b0;
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h8) begin n_fail++; $display("FAIL w1c_set_wins: got %h required 00000008", o_rdata); end
        bus_write(8'h43, 32'h8);
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h required 0", o_rdata); end
        pulse(5'd5);
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h20) begin n_fail++; $display("FAIL en_pend_set: got %h required 00000020", o_rdata); end
        bus_write(8'h05, 32'h4);
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL en_pend_clr: got %h required 0", o_rdata); end
        pulse(5'd31);
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL irq_oob: got %h required 0", o_rdata); end
    endtask

    task automatic test_ignored();
        bus_write(8'h40, 32'h1);
        i_cpu_ack = 1'b1; i_cpu_eoi = 1'b1; tick();
        i_cpu_ack = 1'b0; i_cpu_eoi = 1'b0;
        n_checks++; if ({o_busy, o_cpu_irq} !== 2'b00) begin n_fail++; $display("FAIL stray_hs: got busy,irq=%b required 00", {o_busy, o_cpu_irq}); end
        bus_read(8'h42);
        n_checks++; if (o_rdata !== 32'h3) begin n_fail++; $display("FAIL stray_state: got %h required 00000003", o_rdata); end
    endtask

    task automatic test_async_reset();
        bus_write(8'h24, 32'hAAAA);
        pulse(5'd4);
        tick();
        i_cpu_ack = 1'b1; tick(); i_cpu_ack = 1'b0;
        pulse(5'd7);
        n_checks++; if ({o_busy, o_cur, o_vector} !== {1'b1, 5'd4, 16'hAAAA}) begin n_fail++; $display("FAIL rst_pre: got busy=%b cur=%0d vec=%h required 1 4 aaaa", o_busy, o_cur, o_vector); end
        #2;
        i_rst = 1'b0;
        #1;
        n_checks++; if ({o_rdata, o_rdy, o_en, o_busy, o_cpu_irq, o_vector, o_cur} !== '0) begin n_fail++; $display("FAIL arst_outputs: got %h required 0", {o_rdata, o_rdy, o_en, o_busy, o_cpu_irq, o_vector, o_cur}); end
        n_checks++; if (o_reg !== '0) begin n_fail++; $display("FAIL arst_reg: got %h required 0", o_reg); end
        i_rst = 1'b1;
        bus_read(8'h42);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL arst_state: got %h required 0", o_rdata); end
        bus_read(8'h41);
        n_checks++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL arst_pending: got %h required 0", o_rdata); end
    endtask

    initial begin
        test_reset();
        test_cfg_rw();
        test_dispatch();
        test_priority();
        test_timeout();
        test_w1c();
        test_ignored();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vic_ctrl.md
Name: vic_ctrl

Overview:
- Synchronous controller around the vectored interrupt unit.
- Owns the per-line configuration register file (en/rise/fall/level) and the 31-entry vector table, both programmed over a simple CPU register bus.
- Latches interrupt events into a pending bitmap and selects the highest-priority line.
- Runs the CPU request/acknowledge/end-of-interrupt handshake, and drives the busy line whose falling edge tells the interrupt unit that service has finished.

Parameters:
N_IRQ, 31, number of interrupt lines (bitmap width; config bus is 4*N_IRQ)
VEC_W, 16, vector (handler address) width
ACK_TIMEOUT, 255, cycles in REQ without i_cpu_ack before the request is withdrawn

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-low
i_wr  in  1  bus write strobe
i_rd  in  1  bus read strobe
i_addr  in  8  register address
i_wdata  in  32  write data
o_rdata  out  32  read data, registered
o_rdy  out  1  bus access complete, 1-cycle pulse
i_irq_pulse  in  1  event from interrupt unit, synchronous, 1 cycle
i_irq_addr  in  5  line number qualifying i_irq_pulse
o_reg  out  4*N_IRQ  config to interrupt unit; o_reg[4i+3:4i] = {en,rise,fall,level} of line i
o_en  out  1  global enable to interrupt unit
o_busy  out  1  service in progress, to interrupt unit
o_cpu_irq  out  1  interrupt request to CPU
o_vector  out  VEC_W  handler address of current line
o_cur  out  5  line currently requested/serviced
i_cpu_ack  in  1  CPU accepted request
i_cpu_eoi  in  1  CPU finished handler

Behaviour:
- Reset (i_rst=0, async): all outputs 0, config/vectors/pending 0, FSM=IDLE, timeout counter 0.
- Register map:
  - 0x00-0x1E: cfg[i], bits[3:0].
  - 0x20-0x3E: vec[i], bits[VEC_W-1:0].
  - 0x40: CTRL, bit0 = global enable (o_en).
  - 0x41: PENDING, read-only bitmap.
  - 0x42: CUR, read-only {state[1:0] at bits 9:8, o_cur at bits 4:0}.
  - 0x43: PEND_CLR, write-1-to-clear.
  - Unmapped addresses: read 0, writes ignored.
- Bus timing:
  - Write takes effect at the clock edge where i_wr is sampled.
  - Read data appears in o_rdata one cycle after i_rd.
  - o_rdy pulses one cycle after either strobe.
  - i_wr and i_rd together: the write is performed, o_rdata returns the pre-write value.
- Pending update, each cycle, in priority order:
  1. set pending[i_irq_addr] when i_irq_pulse (set beats W1C and dispatch clear);
  2. clear bits written 1 to PEND_CLR;
  3. clear the pending bit of any line whose cfg en bit is written 0.
  - i_irq_addr >= N_IRQ is ignored.
- FSM: IDLE -> REQ -> SERVICE -> DONE -> IDLE.
  - IDLE: if o_en and pending != 0, select the lowest-index set bit (line 0 = highest priority). o_cur <= line, o_vector <= vec[line], clear that pending bit, go REQ. Decision to o_cpu_irq high: 1 cycle.
  - REQ: o_cpu_irq=1, counter increments each cycle.
    - i_cpu_ack: go SERVICE, o_cpu_irq falls next cycle.
    - Counter reaches ACK_TIMEOUT, or o_en cleared: withdraw o_cpu_irq, re-set pending[o_cur], counter=0, go IDLE.
    - ack and timeout in the same cycle: ack wins.
  - SERVICE: o_busy=1.
    - i_cpu_eoi: go DONE.
    - Clearing o_en does not abort SERVICE.
    - A new pulse on o_cur re-sets its pending bit.
  - DONE: o_busy=0 for exactly one cycle (guaranteed falling edge to the interrupt unit), then IDLE. No dispatch in DONE.
- i_cpu_ack outside REQ and i_cpu_eoi outside SERVICE are ignored.
- Vector-table writes after dispatch do not change o_vector until the next dispatch.

Test Plan:
- Reset, then write cfg[5]=4'b1100 and read back: o_reg[23:20]=4'hC, o_rdata=0x0000000C one cycle after i_rd; o_rdy pulses.
- vec[5]=0x1234, CTRL=1, pulse line 5 -> o_cpu_irq=1 two cycles later, o_vector=0x1234, o_cur=5; ack -> o_busy=1; eoi -> DONE shows o_busy=0 for 1 cycle; PENDING=0.
- Pulses on lines 9 and 2 in the same idle window -> line 2 dispatched first; after its eoi, line 9 dispatched after DONE+IDLE (no back-to-back busy).
- ACK_TIMEOUT=8, pulse line 3, no ack -> o_cpu_irq drops after 8 REQ cycles, PENDING bit 3 = 1, redispatch on next IDLE cycle.
- PEND_CLR write 0x8 in the same cycle as a pulse on line 3 -> PENDING bit 3 remains 1; a later PEND_CLR alone clears it.
- Assert i_rst during SERVICE -> all outputs 0 immediately (async), FSM=IDLE, pending cleared.
